// File: rtl/pipe_carry_adder_pkg.sv
// Shared constants for the pipelined carry adder: default geometry and op encoding.
package pipe_carry_adder_pkg;

  localparam int unsigned PCA_WIDTH = 32;
  localparam int unsigned PCA_CHUNK = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipe_carry_adder_stage.sv
// One pipeline slice: CHUNK-bit add with carry, valid and partial overflow registered.
module pca_stage #(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_valid,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int unsigned CW = CHUNK + 1;

  logic [CHUNK:0] w_total;
  logic           w_ovf;

  logic             r_valid;
  logic [CHUNK-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  assign w_total = CW'(i_a) + CW'(i_b) + CW'(i_carry);
  // Only meaningful in the most significant slice, where chunk MSB is the word MSB.
  assign w_ovf   = (i_a[CHUNK-1] == i_b[CHUNK-1]) && (w_total[CHUNK-1] != i_a[CHUNK-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      r_sum   <= w_total[CHUNK-1:0];
      r_carry <= w_total[CHUNK];
      r_ovf   <= w_ovf;
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/pipe_carry_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry rippling through registers.
module pipe_carry_adder
  import pipe_carry_adder_pkg::*;
#(
  parameter int unsigned WIDTH = PCA_WIDTH,
  parameter int unsigned CHUNK = PCA_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0) begin : g_bad_cfg
    $error("pipe_carry_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Per-stage words: operand bits above the stage still raw, bits at and below it already summed.
  logic [WIDTH-1:0] w_src_x [STAGES];
  logic [WIDTH-1:0] w_src_b [STAGES];
  logic             w_src_c [STAGES];
  logic             w_src_v [STAGES];
  logic [WIDTH-1:0] w_x     [STAGES];
  logic [WIDTH-1:0] w_bq    [STAGES];
  logic [CHUNK-1:0] w_sum   [STAGES];
  logic             w_carry [STAGES];
  logic             w_valid [STAGES];
  logic             w_ovf   [STAGES];

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign w_b_eff   = (op_sub == OP_SUB) ? ~b : b;
  assign w_cin_eff = (op_sub == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned     LO   = k * CHUNK;
    localparam logic [WIDTH-1:0] KEEP = ~(WIDTH'({CHUNK{1'b1}}) << LO);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_b;

    if (k == 0) begin : g_head
      assign w_src_x[k] = a;
      assign w_src_b[k] = w_b_eff;
      assign w_src_c[k] = w_cin_eff;
      assign w_src_v[k] = in_valid;
    end else begin : g_body
      assign w_src_x[k] = w_x[k-1];
      assign w_src_b[k] = w_bq[k-1];
      assign w_src_c[k] = w_carry[k-1];
      assign w_src_v[k] = w_valid[k-1];
    end

    pca_stage #(.CHUNK(CHUNK)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_advance),
      .i_valid   (w_src_v[k]),
      .i_a       (w_src_x[k][LO +: CHUNK]),
      .i_b       (w_src_b[k][LO +: CHUNK]),
      .i_carry   (w_src_c[k]),
      .o_valid   (w_valid[k]),
      .o_sum     (w_sum[k]),
      .o_carry   (w_carry[k]),
      .o_ovf     (w_ovf[k])
    );

    // Carry the rest of the transaction alongside the slice adder.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_x <= '0;
        r_b <= '0;
      end else if (w_advance) begin
        r_x <= w_src_x[k];
        r_b <= w_src_b[k];
      end
    end

    assign w_x[k]  = (r_x & KEEP) | (WIDTH'(w_sum[k]) << LO);
    assign w_bq[k] = r_b;
  end

  assign out_valid = w_valid[STAGES-1];
  assign sum       = w_x[STAGES-1];
  assign cout      = w_carry[STAGES-1];
  assign ovf       = w_ovf[STAGES-1];

endmodule

// File: doc/pipe_carry_adder.md
PIPE_CARRY_ADDER -- requirements
Module: pipe_carry_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per pipeline stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 op_sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  final carry-out (subtract: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 STAGES = WIDTH/CHUNK; WIDTH not divisible by CHUNK, or CHUNK > WIDTH, SHALL fail elaboration.
REQ-017 Stage k adds operand bits [k*CHUNK +: CHUNK] with the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-018 Add: effective B = b, effective carry-in = cin; subtract: effective B = ~b, effective carry-in = 1, cin ignored.
REQ-019 Upper operand chunks are delayed with the transaction; completed lower sum chunks travel with it, so sum, cout and ovf emerge aligned.
REQ-020 ovf = (A[MSB] == effB[MSB]) && (sum[MSB] != A[MSB]), evaluated in the last stage.
REQ-021 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-022 advance = !out_valid || out_ready; in_ready = advance; every stage register, including its valid bit, loads only when advance is 1.
REQ-023 Latency: a result accepted at edge N appears with out_valid = 1 after edge N+STAGES-1 when no stall occurs; stalls add cycle-for-cycle.
REQ-024 Throughput: one operation per cycle while out_ready = 1.
REQ-025 Results leave in acceptance order; no loss, duplication or reordering under any out_ready pattern.
REQ-026 While out_valid = 1 and out_ready = 0, sum, cout and ovf are held stable.
REQ-027 Bubbles (in_valid = 0 while advancing) propagate as invalid stages and never produce out_valid.
REQ-028 Simultaneous accept and emit in one cycle is legal and lossless when advance = 1.

Reset
REQ-029 When rst_n = 0 at a rising edge, all stage valid bits clear; out_valid = 0 and in_ready = 1 from the next cycle.
REQ-030 sum, cout and ovf reset to 0; datapath registers other than valid bits need not reset.
REQ-031 Reset mid-operation discards all in-flight operations; none appears after reset release.

Structure
REQ-032 A shared package holds the default WIDTH/CHUNK constants and the add/subtract op encoding.
REQ-033 One sub-module, pca_stage: CHUNK-bit adder with carry-in/out and registered outputs, instantiated STAGES times via generate.

Verification (WIDTH = 32, CHUNK = 8, latency 4 cycles)
REQ-034 Reset: rst_n low 2 cycles, then high -> out_valid = 0, in_ready = 1, sum = 0.
REQ-035 Carry ripple: a = 0xFFFFFFFF, b = 0x00000001, cin = 0, add -> sum = 0x00000000, cout = 1, ovf = 0, 4 cycles after accept.
REQ-036 Subtract: 0x00000005 - 0x00000007 -> 0xFFFFFFFE, cout = 0, ovf = 0; 0x80000000 - 0x00000001 -> 0x7FFFFFFF, cout = 1, ovf = 1.
REQ-037 Back-pressure: stream 8 random ops, drop out_ready for 3 cycles mid-stream -> in_ready = 0 while stalled, outputs held, all 8 results in order and matching a reference model.
REQ-038 Throughput: 16 consecutive ops with out_ready = 1 -> 16 results on 16 consecutive cycles.
REQ-039 Reset mid-flight: fill pipeline with 4 ops, assert rst_n = 0 for 1 cycle -> out_valid = 0 afterwards, no stale result emitted.
